// File: rtl/array_tap_ctrl_if.sv
// array_tap_ctrl_if -- tap-side bundle for the window-position controller.
//   master : drives tapvs/tapde (the video tap) and observes the qualifiers
//   slave  : the controller; receives tapvs/tapde and drives ctlvs, ctlde,
//            col, row, win_valid, edge_l/r/t/b, line_err, frame_err
// With ARRAY_TAP_CTRL_STATS_EN defined the bundle also carries frame_cnt,
// line_err_cnt and frame_err_cnt.
interface array_tap_ctrl_if #(
  parameter int CSIZE = 12,
  parameter int RSIZE = 11
);
  logic             tapvs;
  logic             tapde;
  logic             ctlvs;
  logic             ctlde;
  logic [CSIZE-1:0] col;
  logic [RSIZE-1:0] row;
  logic             win_valid;
  logic             edge_l;
  logic             edge_r;
  logic             edge_t;
  logic             edge_b;
  logic             line_err;
  logic             frame_err;
`ifdef ARRAY_TAP_CTRL_STATS_EN
  logic [15:0]      frame_cnt;
  logic [15:0]      line_err_cnt;
  logic [15:0]      frame_err_cnt;

  modport master (
    output tapvs, tapde,
    input  ctlvs, ctlde, col, row, win_valid, edge_l, edge_r, edge_t, edge_b,
           line_err, frame_err, frame_cnt, line_err_cnt, frame_err_cnt
  );
  modport slave (
    input  tapvs, tapde,
    output ctlvs, ctlde, col, row, win_valid, edge_l, edge_r, edge_t, edge_b,
           line_err, frame_err, frame_cnt, line_err_cnt, frame_err_cnt
  );
`else
  modport master (
    output tapvs, tapde,
    input  ctlvs, ctlde, col, row, win_valid, edge_l, edge_r, edge_t, edge_b,
           line_err, frame_err
  );
  modport slave (
    input  tapvs, tapde,
    output ctlvs, ctlde, col, row, win_valid, edge_l, edge_r, edge_t, edge_b,
           line_err, frame_err
  );
`endif
endinterface

// File: rtl/array_tap_ctrl.sv
// array_tap_ctrl -- window-centre position tracker for a SIZE x SIZE video tap.
// Follows the tap's aligned vs/de stream, tracks the column/row of the window
// centre, flags full-neighbourhood validity and per-edge borders, and checks
// line/frame geometry against VIDEO_WIDTH x VIDEO_HEIGHT.
// Ports:
//   clock : single clock
//   rst   : asynchronous, active-high reset
//   bus   : array_tap_ctrl_if.slave (tapvs/tapde in; ctlvs, ctlde, col, row,
//           win_valid, edge_l/r/t/b, line_err, frame_err out)
// All outputs are registered, one cycle after tapvs/tapde.
// Optional: define ARRAY_TAP_CTRL_STATS_EN to add frame_cnt, line_err_cnt
// and frame_err_cnt (16-bit) to the bus.
module array_tap_ctrl #(
  parameter int SIZE         = 3,
  parameter int VIDEO_WIDTH  = 1920,
  parameter int VIDEO_HEIGHT = 1080,
  parameter int CSIZE        = 12,
  parameter int RSIZE        = 11
) (
  input  logic            clock,
  input  logic            rst,
  array_tap_ctrl_if.slave bus
);
  localparam int R = (SIZE - 1) / 2;
  localparam logic [CSIZE-1:0] COL_LO   = CSIZE'(R);
  localparam logic [CSIZE-1:0] COL_HI   = CSIZE'(VIDEO_WIDTH - 1 - R);
  localparam logic [CSIZE-1:0] COL_LAST = CSIZE'(VIDEO_WIDTH - 1);
  localparam logic [CSIZE-1:0] COL_MAX  = {CSIZE{1'b1}};
  localparam logic [RSIZE-1:0] ROW_LO   = RSIZE'(R);
  localparam logic [RSIZE-1:0] ROW_HI   = RSIZE'(VIDEO_HEIGHT - 1 - R);
  localparam logic [RSIZE-1:0] ROW_CNT  = RSIZE'(VIDEO_HEIGHT);
  localparam logic [RSIZE-1:0] ROW_MAX  = {RSIZE{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, LINE = 2'd2} state_t;

  function automatic logic [CSIZE-1:0] col_sat_inc(input logic [CSIZE-1:0] v);
    return (v == COL_MAX) ? v : v + CSIZE'(1);
  endfunction

  function automatic logic [RSIZE-1:0] row_sat_inc(input logic [RSIZE-1:0] v);
    return (v == ROW_MAX) ? v : v + RSIZE'(1);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ctlvs_r, ctlde_r;
  logic [CSIZE-1:0] col_r;
  logic [RSIZE-1:0] row_r;
  logic [RSIZE-1:0] line_cnt_r;   // completed lines in the current frame
  logic             win_valid_r, edge_l_r, edge_r_r, edge_t_r, edge_b_r;
  logic             line_err_r, frame_err_r;

  logic             vs_rise_s, active_s, first_s, line_end_s, line_bad_s;
  logic             frame_bad_s;
  logic [CSIZE-1:0] col_nxt_s;
  logic [RSIZE-1:0] row_nxt_s;

  // Next-state and qualifier decode. A vs rise restarts the frame and the
  // de input is then judged as if already in BLANK.
  always_comb begin
    vs_rise_s   = bus.tapvs & ~ctlvs_r;
    active_s    = bus.tapde & (vs_rise_s | (state_r != IDLE));
    first_s     = vs_rise_s | (state_r != LINE);
    col_nxt_s   = first_s ? {CSIZE{1'b0}} : col_sat_inc(col_r);
    row_nxt_s   = vs_rise_s ? {RSIZE{1'b0}} : line_cnt_r;
    line_end_s  = ~vs_rise_s & (state_r == LINE) & ~bus.tapde;
    // A saturated column can never equal the configured width.
    line_bad_s  = (col_r == COL_MAX) | (col_r != COL_LAST);
    frame_bad_s = (state_r != IDLE) & (line_cnt_r != {RSIZE{1'b0}}) &
                  (line_cnt_r != ROW_CNT);
    state_nxt_s = state_r;
    if (vs_rise_s) begin
      state_nxt_s = bus.tapde ? LINE : BLANK;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        BLANK:   state_nxt_s = bus.tapde ? LINE : BLANK;
        LINE:    state_nxt_s = bus.tapde ? LINE : BLANK;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM, position counters and registered qualifiers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ctlvs_r     <= 1'b0;
      ctlde_r     <= 1'b0;
      col_r       <= {CSIZE{1'b0}};
      row_r       <= {RSIZE{1'b0}};
      line_cnt_r  <= {RSIZE{1'b0}};
      win_valid_r <= 1'b0;
      edge_l_r    <= 1'b0;
      edge_r_r    <= 1'b0;
      edge_t_r    <= 1'b0;
      edge_b_r    <= 1'b0;
      line_err_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ctlvs_r     <= bus.tapvs;
      ctlde_r     <= bus.tapde;
      line_err_r  <= line_end_s & line_bad_s;
      frame_err_r <= vs_rise_s & frame_bad_s;
      win_valid_r <= active_s & (col_nxt_s >= COL_LO) & (col_nxt_s <= COL_HI) &
                     (row_nxt_s >= ROW_LO) & (row_nxt_s <= ROW_HI);
      edge_l_r    <= active_s & (col_nxt_s < COL_LO);
      edge_r_r    <= active_s & (col_nxt_s > COL_HI);
      edge_t_r    <= active_s & (row_nxt_s < ROW_LO);
      edge_b_r    <= active_s & (row_nxt_s > ROW_HI);
      if (active_s | vs_rise_s) begin
        col_r <= col_nxt_s;
      end else begin
        col_r <= col_r;
      end
      // row output only moves with a qualified pixel
      if (active_s) begin
        row_r <= row_nxt_s;
      end else begin
        row_r <= row_r;
      end
      if (vs_rise_s) begin
        line_cnt_r <= {RSIZE{1'b0}};
      end else if (line_end_s) begin
        line_cnt_r <= row_sat_inc(line_cnt_r);
      end else begin
        line_cnt_r <= line_cnt_r;
      end
    end
  end

  assign bus.ctlvs     = ctlvs_r;
  assign bus.ctlde     = ctlde_r;
  assign bus.col       = col_r;
  assign bus.row       = row_r;
  assign bus.win_valid = win_valid_r;
  assign bus.edge_l    = edge_l_r;
  assign bus.edge_r    = edge_r_r;
  assign bus.edge_t    = edge_t_r;
  assign bus.edge_b    = edge_b_r;
  assign bus.line_err  = line_err_r;
  assign bus.frame_err = frame_err_r;

`ifdef ARRAY_TAP_CTRL_STATS_EN
  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] frame_cnt_r, line_err_cnt_r, frame_err_cnt_r;

  // Event statistics: frame count wraps, error counts saturate.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      frame_cnt_r     <= 16'd0;
      line_err_cnt_r  <= 16'd0;
      frame_err_cnt_r <= 16'd0;
    end else begin
      frame_cnt_r     <= vs_rise_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
      line_err_cnt_r  <= (line_end_s & line_bad_s) ? sat16_inc(line_err_cnt_r)
                                                   : line_err_cnt_r;
      frame_err_cnt_r <= (vs_rise_s & frame_bad_s) ? sat16_inc(frame_err_cnt_r)
                                                   : frame_err_cnt_r;
    end
  end

  assign bus.frame_cnt     = frame_cnt_r;
  assign bus.line_err_cnt  = line_err_cnt_r;
  assign bus.frame_err_cnt = frame_err_cnt_r;
`endif
endmodule

// File: doc/array_tap_ctrl.md
# array_tap_ctrl

Window-position controller for the SIZE×SIZE video tap. It watches the tap's aligned output stream (vs/de) and tracks the column and row of the window centre. It flags whether the full neighbourhood is inside the image, and raises border flags per edge. It checks line and frame geometry against the configured raster and reports errors. Downstream filter kernels (median, Sobel, Gaussian) use its registered qualifiers to select between computing and replicating or zeroing the window.

## Interface
- SIZE, 3, window edge; odd, ≥3; R = (SIZE-1)/2
- VIDEO_WIDTH, 1920, active pixels per line
- VIDEO_HEIGHT, 1080, active lines per frame
- CSIZE, 12, column counter width; 2^CSIZE > VIDEO_WIDTH
- RSIZE, 11, row counter width; 2^RSIZE > VIDEO_HEIGHT
- clock  in  1  single clock for the block
- rst  in  1  asynchronous, active-high reset
- tapvs  in  1  vsync from the tap output, aligned with the window data
- tapde  in  1  data enable from the tap output, aligned with the window data
- ctlvs  out  1  tapvs delayed by 1 cycle
- ctlde  out  1  tapde delayed by 1 cycle
- col  out  CSIZE  window-centre column of the pixel qualified by ctlde
- row  out  RSIZE  window-centre row of the pixel qualified by ctlde
- win_valid  out  1  ctlde && R≤col≤VIDEO_WIDTH-1-R && R≤row≤VIDEO_HEIGHT-1-R
- edge_l, edge_r, edge_t, edge_b  out  1 each  ctlde && (col<R / col>VIDEO_WIDTH-1-R / row<R / row>VIDEO_HEIGHT-1-R)
- line_err  out  1  1-cycle pulse: the line that just ended had a pixel count ≠ VIDEO_WIDTH
- frame_err  out  1  1-cycle pulse: the frame that just ended had a line count ≠ VIDEO_HEIGHT

## Operation
- FSM states: IDLE, BLANK, LINE.
  - IDLE: entered on reset; tapde is ignored; all qualifiers stay 0.
  - A tapvs rising edge in any state resets the column and row counters and moves the FSM to BLANK.
  - BLANK to LINE: on tapde=1.
  - LINE to BLANK: on tapde=0.
- Column counter:
  - Starts at 0 on the first de cycle of a line.
  - Increments on each subsequent de cycle.
  - Saturates at 2^CSIZE-1.
- Row counter:
  - Increments on each LINE to BLANK transition.
  - Saturates at 2^RSIZE-1.
- Line check: on LINE to BLANK, line_err pulses if the final column count + 1 ≠ VIDEO_WIDTH. Saturation counts as a mismatch.
- Frame check: on a tapvs rising edge, frame_err pulses if the row count ≠ VIDEO_HEIGHT.
  - Not checked on the first vs after reset, when leaving IDLE.
  - Not checked when the row count is 0 (empty frame).
- Lines beyond VIDEO_HEIGHT:
  - col and row keep counting up to saturation.
  - win_valid=0 and edge_b=1 for those lines.
- Pixels beyond VIDEO_WIDTH: win_valid=0 and edge_r=1.
- tapde=1 while in IDLE is ignored. No counting takes place and no errors are reported.
- tapvs and a tapde edge in the same cycle: the vs restart wins. The de edge is then evaluated from BLANK, so tapde=1 in that cycle starts line 0.

## Timing
- Every output is registered with a latency of 1 cycle from tapvs/tapde. col, row, the flags and ctlde for a pixel are all valid in the same cycle.
- line_err is asserted in the cycle after the de falling edge. frame_err is asserted in the cycle after the vs rising edge.
- Reset values: ctlvs=0, ctlde=0, col=0, row=0, win_valid=0, all edge_*=0, line_err=0, frame_err=0. After reset the FSM is in IDLE.
- Reset mid-frame: outputs clear asynchronously. The block re-locks at the next tapvs rising edge, and no error is reported for the truncated frame.
- col and row hold their last values while ctlde=0. Consumers qualify them with ctlde.

## Configuration
- ARRAY_TAP_CTRL_STATS_EN defined: the block adds three outputs.
  - frame_cnt[15:0]: wrapping count of tapvs rising edges.
  - line_err_cnt[15:0]: saturating count of line_err pulses.
  - frame_err_cnt[15:0]: saturating count of frame_err pulses.
  - All three reset to 0.
- Macro undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
All scenarios use SIZE=3, VIDEO_WIDTH=8, VIDEO_HEIGHT=6.
- Nominal frame (vs pulse, then 6 lines of 8 de cycles):
  - win_valid is high for col 1..6 on rows 1..4, i.e. 24 cycles.
  - edge_t on row 0, edge_b on row 5, edge_l on col 0, edge_r on col 7.
  - No errors.
- Short line (line 2 has 7 de cycles): line_err pulses exactly once, 1 cycle after that de falls. The second vs then gives frame_err=0, because 6 lines were still counted.
- Frame with 7 lines, then vs:
  - frame_err pulses once.
  - Row 6 has edge_b=1 and win_valid=0.
  - Row 6 on the ctlde output reads 6.
- tapde toggling before the first vs after reset: all outputs stay 0 apart from ctlde, which follows tapde delayed by 1 cycle. No error pulses.
- Reset asserted at row 3, col 4: outputs are 0 within the same cycle. The next full frame behaves as in scenario 1, with no spurious frame_err.
- With ARRAY_TAP_CTRL_STATS_EN defined: after 3 frames where the second frame contains one short line, the outputs read frame_cnt=3, line_err_cnt=1, frame_err_cnt=0.
